fuzzy_risk_sequencer: RTL and testbench

//  Sequences the fuzzy risk engine from raw sensor samples. Clamps and averages
//  2**AVG_LOG2 rainfall/soil-moisture samples, then launches one engine

---
 rtl/fuzzy_pkg.sv | 18 +
 rtl/fuzzy_sample_avg.sv | 54 +++++
 rtl/fuzzy_risk_sequencer.sv | 127 ++++++++++++
 tb/tb_fuzzy_risk_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// rtl/fuzzy_pkg.sv - shared state encoding, limits and helpers for the fuzzy risk path
package fuzzy_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        UPDATE = 2'd3
    } seq_state_t;

    localparam logic [7:0] PCT_MAX = 8'd100;

    // Shared with the fuzzy engine so both sides saturate identically.
    function automatic logic [7:0] clamp_pct(input logic [7:0] value);
        return (value > PCT_MAX) ? PCT_MAX : value;
    endfunction

endpackage

// File: rtl/fuzzy_sample_avg.sv
// rtl/fuzzy_sample_avg.sv - clamps and accumulates a window of rain/soil samples
// The averages are combinational and include the current sample, valid with window_done.
module fuzzy_sample_avg
    import fuzzy_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic [7:0] rain_in,
    input  logic [7:0] soil_in,
    output logic       window_done,
    output logic [7:0] rain_avg,
    output logic [7:0] soil_avg
);

    localparam int AW = 8 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0] rain_acc;
    logic [AW-1:0] soil_acc;
    logic [AW-1:0] rain_sum;
    logic [AW-1:0] soil_sum;
    logic [CW-1:0] count;

    always_comb begin
        rain_sum    = rain_acc + AW'(clamp_pct(rain_in));
        soil_sum    = soil_acc + AW'(clamp_pct(soil_in));
        window_done = sample_en && (count == LAST);
        rain_avg    = rain_sum[AW-1:AVG_LOG2];
        soil_avg    = soil_sum[AW-1:AVG_LOG2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rain_acc <= '0;
            soil_acc <= '0;
            count    <= '0;
        end else if (sample_en) begin
            if (window_done) begin
                rain_acc <= '0;
                soil_acc <= '0;
                count    <= '0;
            end else begin
                rain_acc <= rain_sum;
                soil_acc <= soil_sum;
                count    <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fuzzy_risk_sequencer.sv
// rtl/fuzzy_risk_sequencer.sv - averages sensor windows, launches and supervises the fuzzy engine
// Registers the engine risk and drives a hysteretic alarm.
module fuzzy_risk_sequencer
    import fuzzy_pkg::*;
#(
    parameter int AVG_LOG2  = 2,
    parameter int TIMEOUT   = 64,
    parameter int ALARM_ON  = 70,
    parameter int ALARM_OFF = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic [7:0] rain_in,
    input  logic [7:0] soil_in,
    output logic       fz_start,
    output logic [7:0] fz_rain,
    output logic [7:0] fz_soil,
    input  logic       fz_done,
    input  logic [7:0] fz_risk,
    output logic [7:0] risk_out,
    output logic       risk_valid,
    output logic       alarm,
    output logic       timeout_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0] ON_LVL  = 8'(ALARM_ON);
    localparam logic [7:0] OFF_LVL = 8'(ALARM_OFF);

    seq_state_t    state;
    seq_state_t    state_next;
    logic [TW-1:0] wait_count;
    logic          wait_expired;
    logic          sample_en;
    logic          window_done;
    logic [7:0]    rain_avg;
    logic [7:0]    soil_avg;

    assign sample_en    = sample_tick && (state == ACCUM);
    assign wait_expired = (wait_count == TO_LAST);
    assign fz_start     = (state == START);
    assign busy         = (state == START) || (state == WAIT);
    assign risk_valid   = (state == UPDATE);

    fuzzy_sample_avg #(
        .AVG_LOG2(AVG_LOG2)
    ) u_avg (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .rain_in    (rain_in),
        .soil_in    (soil_in),
        .window_done(window_done),
        .rain_avg   (rain_avg),
        .soil_avg   (soil_avg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // A result in the same cycle as the deadline still counts.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (window_done) state_next = START;
            START:   state_next = WAIT;
            WAIT: begin
                if (fz_done) begin
                    state_next = UPDATE;
                end else if (wait_expired) begin
                    state_next = ACCUM;
                end
            end
            UPDATE:  state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fz_rain     <= '0;
            fz_soil     <= '0;
            wait_count  <= '0;
            risk_out    <= '0;
            alarm       <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (window_done) begin
                fz_rain <= rain_avg;
                fz_soil <= soil_avg;
            end
            if (state == START) begin
                wait_count <= '0;
            end else if ((state == WAIT) && !fz_done && !wait_expired) begin
                wait_count <= wait_count + 1'b1;
            end
            if ((state == WAIT) && fz_done) begin
                risk_out <= clamp_pct(fz_risk);
            end
            if ((state == WAIT) && !fz_done && wait_expired) begin
                timeout_err <= 1'b1;
            end
            // Between the two thresholds the alarm holds its level.
            if (state == UPDATE) begin
                if (risk_out >= ON_LVL) begin
                    alarm <= 1'b1;
                end else if (risk_out < OFF_LVL) begin
                    alarm <= 1'b0;
                end
            end
            if (sample_tick && (state != ACCUM)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fuzzy_risk_sequencer.sv
// tb/tb_fuzzy_risk_sequencer.sv - directed bench with a window-level reference model
module tb_fuzzy_risk_sequencer;

    localparam int AVG_LOG2 = 2;
    localparam int N        = 1 << AVG_LOG2;
    localparam int TIMEOUT  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic [7:0] rain_in = '0;
    logic [7:0] soil_in = '0;
    logic       fz_done = 1'b0;
    logic [7:0] fz_risk = '0;
    logic       fz_start;
    logic [7:0] fz_rain;
    logic [7:0] fz_soil;
    logic [7:0] risk_out;
    logic       risk_valid;
    logic       alarm;
    logic       timeout_err;
    logic       overrun;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    fuzzy_risk_sequencer #(
        .AVG_LOG2 (AVG_LOG2),
        .TIMEOUT  (TIMEOUT),
        .ALARM_ON (70),
        .ALARM_OFF(50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_tick(sample_tick),
        .rain_in    (rain_in),
        .soil_in    (soil_in),
        .fz_start   (fz_start),
        .fz_rain    (fz_rain),
        .fz_soil    (fz_soil),
        .fz_done    (fz_done),
        .fz_risk    (fz_risk),
        .risk_out   (risk_out),
        .risk_valid (risk_valid),
        .alarm      (alarm),
        .timeout_err(timeout_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pct(input int v);
        return (v > 100) ? 100 : v;
    endfunction

    // Reference model: window samples kept as a list, evaluation tracked as
    // "launch pending", "cycles spent waiting" and "result just accepted".
    int  win_r[$];
    int  win_s[$];
    int  e_rain = 0, e_soil = 0, e_risk = 0;
    bit  e_alarm = 0, e_to = 0, e_ovr = 0;
    bit  m_start = 0, m_upd = 0;
    int  m_wait = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r.delete();
            win_s.delete();
            e_rain = 0; e_soil = 0; e_risk = 0;
            e_alarm = 0; e_to = 0; e_ovr = 0;
            m_start = 0; m_upd = 0; m_wait = -1;
        end else begin
            if (sample_tick && (m_start || m_wait >= 0 || m_upd)) e_ovr = 1;
            if (m_start) begin
                m_start = 0;
                m_wait  = 0;
            end else if (m_wait >= 0) begin
                if (fz_done) begin
                    e_risk = pct(int'(fz_risk));
                    m_wait = -1;
                    m_upd  = 1;
                end else if (m_wait == TIMEOUT - 1) begin
                    e_to   = 1;
                    m_wait = -1;
                end else begin
                    m_wait++;
                end
            end else if (m_upd) begin
                m_upd = 0;
                if (e_risk >= 70) e_alarm = 1;
                else if (e_risk < 50) e_alarm = 0;
            end else if (sample_tick) begin
                win_r.push_back(pct(int'(rain_in)));
                win_s.push_back(pct(int'(soil_in)));
                if (win_r.size() == N) begin
                    e_rain = win_r.sum() / N;
                    e_soil = win_s.sum() / N;
                    win_r.delete();
                    win_s.delete();
                    m_start = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("fz_start",    fz_start,    m_start);
        chk("busy",        busy,        m_start || (m_wait >= 0));
        chk("risk_valid",  risk_valid,  m_upd);
        chk("fz_rain",     fz_rain,     e_rain);
        chk("fz_soil",     fz_soil,     e_soil);
        chk("risk_out",    risk_out,    e_risk);
        chk("alarm",       alarm,       e_alarm);
        chk("timeout_err", timeout_err, e_to);
        chk("overrun",     overrun,     e_ovr);
    end

    task automatic tick(input int r, input int s);
        @(negedge clk);
        sample_tick = 1'b1;
        rain_in     = 8'(r);
        soil_in     = 8'(s);
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    // Returns at the negedge of the UPDATE cycle.
    task automatic engine(input int risk, input int lat);
        repeat (lat) @(negedge clk);
        fz_done = 1'b1;
        fz_risk = 8'(risk);
        @(negedge clk);
        fz_done = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_risk_out", risk_out, 0);
        chk("rst_fz_rain", fz_rain, 0);
        rst_n = 1'b1;

        // Plain average, start exactly one cycle after the closing tick.
        tick(10, 100); tick(20, 100); tick(30, 100); tick(40, 100);
        chk("t1_start", fz_start, 1);
        chk("t1_rain", fz_rain, 25);
        chk("t1_soil", fz_soil, 100);
        engine(80, 3);
        chk("t3_risk80", risk_out, 80);
        chk("t3_valid", risk_valid, 1);
        @(negedge clk);
        chk("t3_valid_once", risk_valid, 0);
        chk("t3_alarm_on", alarm, 1);

        // Clamp of out-of-range samples.
        for (int i = 0; i < N; i++) tick(200, 255);
        chk("t2_rain_clamp", fz_rain, 100);
        chk("t2_soil_clamp", fz_soil, 100);
        engine(60, 1);
        @(negedge clk);
        chk("t3_alarm_hold", alarm, 1);

        tick(50, 1); tick(60, 2); tick(70, 3); tick(80, 4);
        chk("avg65_rain", fz_rain, 65);
        chk("avg_soil2", fz_soil, 2);
        engine(49, 5);
        @(negedge clk);
        chk("t3_alarm_off", alarm, 0);

        for (int i = 0; i < N; i++) tick(5, 5);
        engine(250, 2);
        chk("risk_sat", risk_out, 100);
        @(negedge clk);
        chk("alarm_sat", alarm, 1);

        // Timeout: START plus TIMEOUT wait cycles of busy.
        for (int i = 0; i < N; i++) tick(0, 0);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("t4_busy_cycles", n, 65);
        chk("t4_timeout", timeout_err, 1);
        chk("t4_risk_kept", risk_out, 100);
        chk("t4_alarm_kept", alarm, 1);

        // Stray result in ACCUM must be ignored.
        @(negedge clk);
        fz_done = 1'b1; fz_risk = 8'd10;
        @(negedge clk);
        fz_done = 1'b0;
        chk("stray_done", risk_out, 100);

        for (int i = 0; i < N; i++) tick(10, 0);
        chk("t4_next_rain", fz_rain, 10);
        engine(55, 2);
        chk("risk55", risk_out, 55);
        @(negedge clk);
        chk("alarm_hold55", alarm, 1);

        // Tick during WAIT is dropped and flagged.
        for (int i = 0; i < N; i++) tick(0, 0);
        @(negedge clk);
        sample_tick = 1'b1; rain_in = 8'd100; soil_in = 8'd100;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("t5_overrun", overrun, 1);
        fz_done = 1'b1; fz_risk = 8'd30;
        @(negedge clk);
        fz_done = 1'b0;
        @(negedge clk);
        chk("alarm_off30", alarm, 0);
        tick(4, 0); tick(8, 0); tick(12, 0); tick(16, 0);
        chk("t5_rain_clean", fz_rain, 10);
        chk("t5_soil_clean", fz_soil, 0);
        engine(20, 1);

        // Reset in the middle of WAIT, then a late result.
        for (int i = 0; i < N; i++) tick(90, 90);
        @(negedge clk);
        chk("t6_in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_overrun", overrun, 0);
        chk("t6_fz_rain", fz_rain, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fz_done = 1'b1; fz_risk = 8'd90;
        @(negedge clk);
        fz_done = 1'b0;
        chk("t6_no_valid", risk_valid, 0);
        chk("t6_risk_zero", risk_out, 0);
        chk("t6_alarm_zero", alarm, 0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
